game_state_ctrl: RTL and testbench
==================================

Name: game_state_ctrl

Overview:
- Input-side counterpart to the LED status driver. Turns raw board buttons and the collision flag into the 3-bit game state that drives the RGB status LEDs, plus a flap strobe for the ghost physics.
- Sits between the board pins and the game logic/LED driver.
- state[0]/[1]/[2] map to Blue/Green/Red on LED16/LED17.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive stable cycles needed to accept a button level change (10 ms at 100 MHz).
- OVER_HOLD_CYCLES, 100000000: minimum cycles spent in OVER before a flap press can return to IDLE (1 s).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- btn_flap  in  1  raw flap/start button; asynchronous, bouncy.
- btn_pause  in  1  raw pause button; asynchronous, bouncy.
- collision  in  1  level from game logic, synchronous to clk.
- state  out  3  game state encoding (B=bit0, G=bit1, R=bit2).
- flap  out  1  one-cycle flap strobe, PLAY only.
- play_en  out  1  high while state==PLAY; gates game advance.

Behaviour:
- Reset (async, rst_n=0):
  - state=3'b001 (IDLE).
  - flap=0, play_en=0.
  - All synchronizers, debounced levels and counters = 0.
  - Takes effect immediately, mid-operation included.
- Per button:
  - 2-flop synchronizer.
  - Debouncer: counter increments while the synced value != stable level, and clears when they are equal. When the counter reaches DEBOUNCE_CYCLES-1 with the mismatch still present, the stable level toggles and the counter clears.
  - Press event = stable rising edge; one cycle wide.
  - Releases produce no event. A held button produces exactly one event.
- Encodings: IDLE=001 (blue), PLAY=010 (green), PAUSED=011 (cyan), OVER=100 (red). Other codes are unreachable and recover to IDLE on the next clock.
- Transitions, evaluated per cycle on press events:
  - IDLE: flap press -> PLAY. The start press produces no flap strobe. Pause and collision are ignored.
  - PLAY, in priority order:
    1. collision -> OVER. Any same-cycle presses are discarded and no flap strobe is produced.
    2. pause press -> PAUSED. A same-cycle flap press is discarded.
    3. flap press -> flap=1 for exactly that next cycle; state stays PLAY.
  - PAUSED: pause press -> PLAY. Flap and collision are ignored.
  - OVER:
    - The hold counter clears on entry and saturates at OVER_HOLD_CYCLES.
    - A flap press while the counter < OVER_HOLD_CYCLES is ignored (dropped, not queued).
    - A flap press once the counter has saturated -> IDLE.
- Outputs are registered.
  - play_en == (state==PLAY).
  - Latency for flap: raw btn_flap first sampled high at edge N, and held -> flap high in the cycle following edge N+DEBOUNCE_CYCLES+3.
  - Latency for state: a state change appears on the same edge that flap would have.
- Counter widths are $clog2(param+1). No wrap-around: the hold counter saturates and the debounce counter clears.

Decomposition:
- Shared package game_pkg:
  - State encoding constants ST_IDLE, ST_PLAY, ST_PAUSED, ST_OVER (3 bits each).
  - A state_t typedef.
  - Shared with the LED/colour logic.
- Sub-module btn_debounce: synchronizer + debounce counter + rising-edge pulse; parameter DEBOUNCE_CYCLES; instantiated twice.
- FSM and hold counter live in game_state_ctrl.

Test Plan (DEBOUNCE_CYCLES=4, OVER_HOLD_CYCLES=8):
- Reset: rst_n=0 for 3 cycles -> state=001, flap=0, play_en=0; outputs stable after release with idle buttons.
- Bounce rejection: btn_flap 1,1,0,1,1,0 then low -> state stays 001. Then btn_flap held high from edge N -> state=010 after edge N+7, play_en=1, flap never asserted.
- Hold in PLAY: btn_flap held 30 cycles from edge N -> exactly one flap pulse, in the cycle after edge N+7; none on release.
- Pause: btn_pause and btn_flap pressed together in PLAY -> state=011, no flap. Flap press in PAUSED -> no change. Second pause press -> 010.
- Collision: collision=1 in the same cycle as a flap press event in PLAY -> state=100, no flap, play_en=0. Flap press 3 cycles after entry -> still 100. Flap press after 10 cycles -> 001.
- Async reset: drop rst_n between clock edges while in PLAY -> state=001 and play_en=0 before the next edge.

Source files
------------

// File: rtl/game_pkg.sv
// game_pkg: game state encoding shared by the input controller and the LED colour logic
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b001,
        ST_PLAY   = 3'b010,
        ST_PAUSED = 3'b011,
        ST_OVER   = 3'b100
    } state_t;

endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchronizer, stable-level debouncer and registered press pulse
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic          stable_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
            press    <= 1'b0;
        end else begin
            sync1    <= btn;
            sync2    <= sync1;
            stable_d <= stable;
            press    <= stable & ~stable_d;
            // any agreement with the stable level restarts the qualification window
            if (sync2 == stable)
                cnt <= '0;
            else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable <= ~stable;
                cnt    <= '0;
            end else
                cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/game_state_ctrl.sv
// game_state_ctrl: debounced buttons and collision flag to game state, flap strobe and play enable
import game_pkg::*;

module game_state_ctrl #(
    parameter int DEBOUNCE_CYCLES  = 1000000,
    parameter int OVER_HOLD_CYCLES = 100000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_flap,
    input  logic       btn_pause,
    input  logic       collision,
    output logic [2:0] state,
    output logic       flap,
    output logic       play_en
);

    localparam int HW = $clog2(OVER_HOLD_CYCLES + 1);

    logic          flap_press;
    logic          pause_press;
    logic [HW-1:0] hold;
    state_t        st;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_flap (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_flap),
        .press (flap_press)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_pause),
        .press (pause_press)
    );

    assign state = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= ST_IDLE;
            flap    <= 1'b0;
            play_en <= 1'b0;
            hold    <= '0;
        end else begin
            flap <= 1'b0;
            case (st)
                ST_IDLE: if (flap_press) begin
                    st      <= ST_PLAY;
                    play_en <= 1'b1;
                end
                ST_PLAY: if (collision) begin
                    st      <= ST_OVER;
                    play_en <= 1'b0;
                    hold    <= '0;
                end else if (pause_press) begin
                    st      <= ST_PAUSED;
                    play_en <= 1'b0;
                end else if (flap_press)
                    flap <= 1'b1;
                ST_PAUSED: if (pause_press) begin
                    st      <= ST_PLAY;
                    play_en <= 1'b1;
                end
                ST_OVER: begin
                    // early presses are dropped so a panicked tap cannot skip the game-over screen
                    if (hold != HW'(OVER_HOLD_CYCLES))
                        hold <= hold + 1'b1;
                    else if (flap_press)
                        st <= ST_IDLE;
                end
                default: begin
                    st      <= ST_IDLE;
                    play_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_state_ctrl.sv
// tb_game_state_ctrl: scenario tasks with a flap-pulse scoreboard for game_state_ctrl
module tb_game_state_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       btn_flap = 1'b0;
    logic       btn_pause = 1'b0;
    logic       collision = 1'b0;
    logic [2:0] state;
    logic       flap;
    logic       play_en;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int exp_q[$];

    game_state_ctrl #(.DEBOUNCE_CYCLES(4), .OVER_HOLD_CYCLES(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_flap  (btn_flap),
        .btn_pause (btn_pause),
        .collision (collision),
        .state     (state),
        .flap      (flap),
        .play_en   (play_en)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // every observed flap pulse must match the cycle queued when its press was driven
    always @(negedge clk) begin
        if (rst_n && flap) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL flap_unexpected: pulse at cycle %0d, none required", cyc);
            end else begin
                int e;
                e = exp_q.pop_front();
                if (cyc !== e) begin
                    fails++;
                    $display("FAIL flap_cycle: pulse at cycle %0d, required %0d", cyc, e);
                end
            end
        end
        if (rst_n) begin
            tests++;
            if (play_en !== (state === 3'b010)) begin
                fails++;
                $display("FAIL play_en_track: play_en=%b with state=%b", play_en, state);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(3);
        tests += 3;
        if (state !== 3'b001) begin fails++; $display("FAIL reset_state: got %b, required 001", state); end
        if (flap !== 1'b0) begin fails++; $display("FAIL reset_flap: got %b, required 0", flap); end
        if (play_en !== 1'b0) begin fails++; $display("FAIL reset_play_en: got %b, required 0", play_en); end
        rst_n = 1'b1;
        tick(8);
        tests += 2;
        if (state !== 3'b001) begin fails++; $display("FAIL idle_state: got %b, required 001", state); end
        if (play_en !== 1'b0) begin fails++; $display("FAIL idle_play_en: got %b, required 0", play_en); end
    endtask

    task automatic test_bounce;
        logic [5:0] pat;
        pat = 6'b011011;
        for (int i = 0; i < 6; i++) begin
            btn_flap = pat[i];
            tick(1);
        end
        btn_flap = 1'b0;
        tick(12);
        tests++;
        if (state !== 3'b001) begin fails++; $display("FAIL bounce_reject: got %b, required 001", state); end
    endtask

    task automatic test_start;
        btn_flap = 1'b1;
        tick(7);
        tests++;
        if (state !== 3'b001) begin fails++; $display("FAIL start_early: got %b, required 001", state); end
        tick(1);
        tests += 2;
        if (state !== 3'b010) begin fails++; $display("FAIL start_state: got %b, required 010", state); end
        if (play_en !== 1'b1) begin fails++; $display("FAIL start_play_en: got %b, required 1", play_en); end
        tick(3);
        btn_flap = 1'b0;
        tick(12);
    endtask

    task automatic test_hold_play;
        btn_flap = 1'b1;
        exp_q.push_back(cyc + 8);
        tick(30);
        btn_flap = 1'b0;
        tick(15);
        tests += 2;
        if (exp_q.size() != 0) begin fails++; $display("FAIL hold_pulse_missing: %0d pending, required 0", exp_q.size()); exp_q.delete(); end
        if (state !== 3'b010) begin fails++; $display("FAIL hold_state: got %b, required 010", state); end
    endtask

    task automatic test_back_to_back;
        btn_flap = 1'b1;
        exp_q.push_back(cyc + 8);
        tick(5);
        btn_flap = 1'b0;
        tick(5);
        btn_flap = 1'b1;
        exp_q.push_back(cyc + 8);
        tick(5);
        btn_flap = 1'b0;
        tick(15);
        tests++;
        if (exp_q.size() != 0) begin fails++; $display("FAIL b2b_pulse_missing: %0d pending, required 0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_pause;
        btn_flap = 1'b1;
        btn_pause = 1'b1;
        tick(8);
        tests += 2;
        if (state !== 3'b011) begin fails++; $display("FAIL pause_state: got %b, required 011", state); end
        if (play_en !== 1'b0) begin fails++; $display("FAIL pause_play_en: got %b, required 0", play_en); end
        tick(3);
        btn_flap = 1'b0;
        btn_pause = 1'b0;
        tick(12);
        btn_flap = 1'b1;
        tick(10);
        tests++;
        if (state !== 3'b011) begin fails++; $display("FAIL paused_flap: got %b, required 011", state); end
        btn_flap = 1'b0;
        tick(12);
        btn_pause = 1'b1;
        tick(8);
        tests += 2;
        if (state !== 3'b010) begin fails++; $display("FAIL resume_state: got %b, required 010", state); end
        if (play_en !== 1'b1) begin fails++; $display("FAIL resume_play_en: got %b, required 1", play_en); end
        btn_pause = 1'b0;
        tick(12);
    endtask

    task automatic test_collision;
        btn_flap = 1'b1;
        tick(4);
        btn_flap = 1'b0;
        tick(3);
        collision = 1'b1;
        tick(1);
        collision = 1'b0;
        tests += 2;
        if (state !== 3'b100) begin fails++; $display("FAIL collide_state: got %b, required 100", state); end
        if (play_en !== 1'b0) begin fails++; $display("FAIL collide_play_en: got %b, required 0", play_en); end
        btn_flap = 1'b1;
        tick(4);
        btn_flap = 1'b0;
        tick(6);
        tests++;
        if (state !== 3'b100) begin fails++; $display("FAIL over_early_press: got %b, required 100", state); end
        tick(6);
        btn_flap = 1'b1;
        tick(4);
        btn_flap = 1'b0;
        tick(3);
        tests++;
        if (state !== 3'b100) begin fails++; $display("FAIL over_before_event: got %b, required 100", state); end
        tick(1);
        tests += 2;
        if (state !== 3'b001) begin fails++; $display("FAIL over_exit: got %b, required 001", state); end
        if (play_en !== 1'b0) begin fails++; $display("FAIL over_exit_play_en: got %b, required 0", play_en); end
        tick(12);
    endtask

    task automatic test_async_reset;
        btn_flap = 1'b1;
        tick(8);
        tests++;
        if (state !== 3'b010) begin fails++; $display("FAIL areset_setup: got %b, required 010", state); end
        btn_flap = 1'b0;
        tick(12);
        #2 rst_n = 1'b0;
        #1;
        tests += 2;
        if (state !== 3'b001) begin fails++; $display("FAIL areset_state: got %b, required 001", state); end
        if (play_en !== 1'b0) begin fails++; $display("FAIL areset_play_en: got %b, required 0", play_en); end
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);
        tests++;
        if (state !== 3'b001) begin fails++; $display("FAIL areset_after: got %b, required 001", state); end
    endtask

    initial begin
        test_reset();
        test_bounce();
        test_start();
        test_hold_play();
        test_back_to_back();
        test_pause();
        test_collision();
        test_async_reset();
        tests++;
        if (exp_q.size() != 0) begin fails++; $display("FAIL final_queue: %0d pending, required 0", exp_q.size()); end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
